// File: rtl/axi_rd_native_bridge.sv
// ---------------------------------------------------------------------------
// axi_rd_native_bridge
//
// Bridges an AXI4 read channel (AR/R) onto a LiteDRAM native user port.
// Each accepted AR burst is split into one native read command per beat.
// Supported burst types are FIXED, INCR and (optionally) WRAP. A small
// tracking FIFO holds {id, len, err} for up to MAX_OUTST bursts in flight.
// The R channel uses the head entry to supply the ID, the last flag and
// the response for each beat. Native read data passes straight through to
// R with no added latency. Bursts that are not legal (wrong size, reserved
// burst type, bad WRAP length or alignment) issue no native commands.
// Instead, len+1 SLVERR beats with zero data are returned in order.
//
// Optional feature macro: AXI_RD_WRAP_EN
//   defined   : WRAP bursts are decoded and issued with wrapping addresses.
//   undefined : WRAP bursts are answered with SLVERR beats, and the
//               wrap-address logic is left out.
//
// Parameters
//   DATA_W     data width in bits (power of two, >= 32)
//   ADDR_W     AXI byte-address width
//   ID_W       AXI ID width
//   MAX_OUTST  tracking-FIFO depth in bursts (power of two, >= 2)
//
// Ports
//   clk                         clock, rising edge
//   rst                         asynchronous reset, active low
//   axi_ar_*                    AXI read-address channel (slave side)
//   axi_r_*                     AXI read-data channel (slave side)
//   native_cmd_*                native command stream (we always 0)
//   native_cmd_payload_addr     word address = byte address >> log2(DATA_W/8)
//   native_rdata_*              native read data, returned in command order
// ---------------------------------------------------------------------------
module axi_rd_native_bridge #(
  parameter int DATA_W    = 256,
  parameter int ADDR_W    = 32,
  parameter int ID_W      = 4,
  parameter int MAX_OUTST = 4
) (
  input  logic                      clk,
  input  logic                      rst,

  input  logic                      axi_ar_valid,
  output logic                      axi_ar_ready,
  input  logic [ADDR_W-1:0]         axi_ar_payload_addr,
  input  logic [1:0]                axi_ar_payload_burst,
  input  logic [7:0]                axi_ar_payload_len,
  input  logic [2:0]                axi_ar_payload_size,
  input  logic [ID_W-1:0]           axi_ar_payload_id,

  output logic                      axi_r_valid,
  input  logic                      axi_r_ready,
  output logic                      axi_r_last,
  output logic [1:0]                axi_r_payload_resp,
  output logic [DATA_W-1:0]         axi_r_payload_data,
  output logic [ID_W-1:0]           axi_r_payload_id,

  output logic                      native_cmd_valid,
  input  logic                      native_cmd_ready,
  output logic                      native_cmd_payload_we,
  output logic [ADDR_W-$clog2(DATA_W/8)-1:0] native_cmd_payload_addr,

  input  logic                      native_rdata_valid,
  output logic                      native_rdata_ready,
  input  logic [DATA_W-1:0]         native_rdata_payload_data
);

  localparam int BPB = DATA_W / 8;
  localparam int OFS = $clog2(BPB);
  localparam int PW  = $clog2(MAX_OUTST);

  localparam logic [ADDR_W-1:0] BPB_A    = ADDR_W'(BPB);
  localparam logic [PW:0]       PTR_ONE  = (PW+1)'(1);
  localparam logic [2:0]        SIZE_OK  = 3'(OFS);

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
  localparam logic [1:0] BURST_RSVD  = 2'd3;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  // Issue-side state
  state_t              state;
  logic [ADDR_W-1:0]   cur_addr;
  logic [ADDR_W-1:0]   next_addr;
  logic [1:0]          cur_burst;
  logic [7:0]          cur_len;
  logic [7:0]          bc;

  // Tracking FIFO; pointers carry one extra bit to tell full from empty
  logic [ID_W-1:0]     trk_id  [MAX_OUTST];
  logic [7:0]          trk_len [MAX_OUTST];
  logic [MAX_OUTST-1:0] trk_err;
  logic [PW:0]         wr_ptr;
  logic [PW:0]         rd_ptr;
  logic                trk_full;
  logic                trk_empty;

  // Response side
  logic [7:0]          rc;
  logic [ID_W-1:0]     h_id;
  logic [7:0]          h_len;
  logic                h_err;

  logic                ar_hs;
  logic                cmd_hs;
  logic                r_hs;
  logic                ar_err;

`ifdef AXI_RD_WRAP_EN
  logic [ADDR_W-1:0]   wrap_mask;
`endif

  assign trk_empty = (wr_ptr == rd_ptr);
  assign trk_full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                     (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

  // Readiness comes only from registered state, never from axi_ar_valid.
  assign axi_ar_ready = (state == IDLE) && !trk_full;
  assign ar_hs        = axi_ar_valid && axi_ar_ready;

  assign native_cmd_valid        = (state == ISSUE);
  assign native_cmd_payload_we   = 1'b0;
  assign native_cmd_payload_addr = cur_addr[ADDR_W-1:OFS];
  assign cmd_hs                  = native_cmd_valid && native_cmd_ready;

  // Legality check of the incoming AR request
  always_comb begin
    ar_err = (axi_ar_payload_size != SIZE_OK) ||
             (axi_ar_payload_burst == BURST_RSVD);
`ifdef AXI_RD_WRAP_EN
    if (axi_ar_payload_burst == BURST_WRAP) begin
      if (!((axi_ar_payload_len == 8'd1) || (axi_ar_payload_len == 8'd3) ||
            (axi_ar_payload_len == 8'd7) || (axi_ar_payload_len == 8'd15))) begin
        ar_err = 1'b1;
      end
      if (axi_ar_payload_addr[OFS-1:0] != '0) begin
        ar_err = 1'b1;
      end
    end
`else
    if (axi_ar_payload_burst == BURST_WRAP) begin
      ar_err = 1'b1;
    end
`endif
  end

  // Address of the next beat. A WRAP burst stays inside a block of
  // (len+1)*BPB bytes: the upper bits stay fixed and the low bits roll over.
  always_comb begin
    next_addr = cur_addr;
`ifdef AXI_RD_WRAP_EN
    wrap_mask = ((ADDR_W'(cur_len) + ADDR_W'(1)) << OFS) - ADDR_W'(1);
`endif
    case (cur_burst)
      BURST_INCR: next_addr = cur_addr + BPB_A;
`ifdef AXI_RD_WRAP_EN
      BURST_WRAP: next_addr = (cur_addr & ~wrap_mask) |
                              ((cur_addr + BPB_A) & wrap_mask);
`endif
      default:    next_addr = cur_addr;
    endcase
  end

  // Issue FSM: latch the burst on AR, then emit one native command per beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cur_addr  <= '0;
      cur_burst <= BURST_FIXED;
      cur_len   <= '0;
      bc        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ar_hs) begin
            cur_addr  <= axi_ar_payload_addr;
            cur_burst <= axi_ar_payload_burst;
            cur_len   <= axi_ar_payload_len;
            bc        <= '0;
            if (!ar_err) begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (cmd_hs) begin
            cur_addr <= next_addr;
            bc       <= bc + 8'd1;
            if (bc == cur_len) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tracking FIFO pointers and response beat counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rc     <= '0;
    end else begin
      if (ar_hs) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (r_hs) begin
        if (axi_r_last) begin
          rd_ptr <= rd_ptr + PTR_ONE;
          rc     <= '0;
        end else begin
          rc <= rc + 8'd1;
        end
      end
    end
  end

  // Tracking FIFO storage
  always_ff @(posedge clk) begin
    if (ar_hs) begin
      trk_id[wr_ptr[PW-1:0]]  <= axi_ar_payload_id;
      trk_len[wr_ptr[PW-1:0]] <= axi_ar_payload_len;
      trk_err[wr_ptr[PW-1:0]] <= ar_err;
    end
  end

  assign h_id  = trk_id[rd_ptr[PW-1:0]];
  assign h_len = trk_len[rd_ptr[PW-1:0]];
  assign h_err = trk_err[rd_ptr[PW-1:0]];

  // R channel. Good bursts forward native data combinationally, and error
  // bursts produce their own SLVERR beats without consuming native data.
  always_comb begin
    axi_r_valid        = 1'b0;
    axi_r_last         = 1'b0;
    axi_r_payload_resp = 2'd0;
    axi_r_payload_data = '0;
    axi_r_payload_id   = '0;
    native_rdata_ready = 1'b0;
    if (!trk_empty) begin
      axi_r_payload_id = h_id;
      axi_r_last       = (rc == h_len);
      if (h_err) begin
        axi_r_valid        = 1'b1;
        axi_r_payload_resp = RESP_SLVERR;
      end else begin
        axi_r_valid        = native_rdata_valid;
        axi_r_payload_data = native_rdata_payload_data;
        native_rdata_ready = axi_r_ready;
      end
    end
  end

  assign r_hs = axi_r_valid && axi_r_ready;

endmodule

// File: tb/tb_axi_rd_native_bridge.sv
// ---------------------------------------------------------------------------
// tb_axi_rd_native_bridge
//
// Self-checking bench for axi_rd_native_bridge (DATA_W 256, ADDR_W 32,
// ID_W 4, MAX_OUTST 4). A behavioural model turns every accepted AR into a
// list of expected native word addresses and expected R beats. It uses
// plain arithmetic on byte addresses. A memory stub answers native commands
// in order with data that is a fixed function of the word address.
// ---------------------------------------------------------------------------
module tb_axi_rd_native_bridge;

  localparam int DATA_W    = 256;
  localparam int ADDR_W    = 32;
  localparam int ID_W      = 4;
  localparam int MAX_OUTST = 4;
  localparam int WORD_W    = 27;

  logic                clk;
  logic                rst;
  logic                axi_ar_valid;
  logic                axi_ar_ready;
  logic [ADDR_W-1:0]   axi_ar_payload_addr;
  logic [1:0]          axi_ar_payload_burst;
  logic [7:0]          axi_ar_payload_len;
  logic [2:0]          axi_ar_payload_size;
  logic [ID_W-1:0]     axi_ar_payload_id;
  logic                axi_r_valid;
  logic                axi_r_ready;
  logic                axi_r_last;
  logic [1:0]          axi_r_payload_resp;
  logic [DATA_W-1:0]   axi_r_payload_data;
  logic [ID_W-1:0]     axi_r_payload_id;
  logic                native_cmd_valid;
  logic                native_cmd_ready;
  logic                native_cmd_payload_we;
  logic [WORD_W-1:0]   native_cmd_payload_addr;
  logic                native_rdata_valid;
  logic                native_rdata_ready;
  logic [DATA_W-1:0]   native_rdata_payload_data;

  axi_rd_native_bridge #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .MAX_OUTST(MAX_OUTST)
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .axi_ar_valid              (axi_ar_valid),
    .axi_ar_ready              (axi_ar_ready),
    .axi_ar_payload_addr       (axi_ar_payload_addr),
    .axi_ar_payload_burst      (axi_ar_payload_burst),
    .axi_ar_payload_len        (axi_ar_payload_len),
    .axi_ar_payload_size       (axi_ar_payload_size),
    .axi_ar_payload_id         (axi_ar_payload_id),
    .axi_r_valid               (axi_r_valid),
    .axi_r_ready               (axi_r_ready),
    .axi_r_last                (axi_r_last),
    .axi_r_payload_resp        (axi_r_payload_resp),
    .axi_r_payload_data        (axi_r_payload_data),
    .axi_r_payload_id          (axi_r_payload_id),
    .native_cmd_valid          (native_cmd_valid),
    .native_cmd_ready          (native_cmd_ready),
    .native_cmd_payload_we     (native_cmd_payload_we),
    .native_cmd_payload_addr   (native_cmd_payload_addr),
    .native_rdata_valid        (native_rdata_valid),
    .native_rdata_ready        (native_rdata_ready),
    .native_rdata_payload_data (native_rdata_payload_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [ID_W-1:0]   id;
    logic              err;
    logic              last;
    logic [DATA_W-1:0] data;
  } beat_t;

  beat_t             exp_r[$];
  logic [WORD_W-1:0] exp_cmd[$];
  logic [DATA_W-1:0] mem_q[$];
  logic [WORD_W-1:0] cmd_log[$];

  int total = 0;
  int bad   = 0;
  int outst = 0;
  int r_fires = 0;
  bit rnd  = 1'b0;
  bit hold = 1'b0;
  bit stall_prev = 1'b0;
  logic [WORD_W-1:0] prev_addr;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] memfn(input logic [WORD_W-1:0] w);
    logic [DATA_W-1:0] d;
    for (int k = 0; k < 8; k++) begin
      d[k*32 +: 32] = ({5'd0, w} * 32'(k + 1)) ^ 32'h9E37_79B9;
    end
    return d;
  endfunction

  function automatic bit model_err(input logic [31:0] addr, input logic [1:0] burst,
                                   input logic [7:0] len, input logic [2:0] size);
    bit e;
    e = (size != 3'd5) || (burst == 2'd3);
`ifdef AXI_RD_WRAP_EN
    if (burst == 2'd2 && !(len == 1 || len == 3 || len == 7 || len == 15)) e = 1'b1;
    if (burst == 2'd2 && (addr % 32) != 0) e = 1'b1;
`else
    if (burst == 2'd2) e = 1'b1;
`endif
    return e;
  endfunction

  // Expected native addresses and R beats for one accepted burst
  task automatic model_ar(input logic [31:0] addr, input logic [1:0] burst,
                          input logic [7:0] len, input logic [2:0] size,
                          input logic [ID_W-1:0] id);
    bit e;
    logic [31:0] blk, base, a;
    e = model_err(addr, burst, len, size);
    for (int i = 0; i <= int'(len); i++) begin
      beat_t b;
      b.id   = id;
      b.err  = e;
      b.last = (i == int'(len));
      b.data = '0;
      if (!e) begin
        if (burst == 2'd0) begin
          a = addr;
        end else if (burst == 2'd1) begin
          a = addr + 32'(i) * 32;
        end else begin
          blk  = (32'(len) + 1) * 32;
          base = addr - (addr % blk);
          a    = base + ((addr - base + 32'(i) * 32) % blk);
        end
        exp_cmd.push_back(a[31:5]);
        b.data = memfn(a[31:5]);
      end
      exp_r.push_back(b);
    end
    outst++;
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_ar_ready"}, axi_ar_ready, 1);
    check_eq({tag, "_r_valid"}, axi_r_valid, 0);
    check_eq({tag, "_r_last"}, axi_r_last, 0);
    check_eq({tag, "_r_resp"}, axi_r_payload_resp, 0);
    check_eq({tag, "_r_data"}, axi_r_payload_data, 0);
    check_eq({tag, "_r_id"}, axi_r_payload_id, 0);
    check_eq({tag, "_cmd_valid"}, native_cmd_valid, 0);
    check_eq({tag, "_cmd_addr"}, native_cmd_payload_addr, 0);
    check_eq({tag, "_cmd_we"}, native_cmd_payload_we, 0);
    check_eq({tag, "_rd_ready"}, native_rdata_ready, 0);
  endtask

  // One clock: sample and check at negedge, then drive after posedge
  task automatic cycle();
    bit ar_fire, cmd_fire, rd_fire, r_fire, head_err, exp_rv;
    @(negedge clk);
    head_err = (exp_r.size() != 0) && exp_r[0].err;
    exp_rv   = (exp_r.size() != 0) && (head_err || native_rdata_valid);
    check_eq("ar_ready", axi_ar_ready, (exp_cmd.size() == 0) && (outst < MAX_OUTST));
    check_eq("cmd_valid", native_cmd_valid, exp_cmd.size() != 0);
    if (native_cmd_valid && exp_cmd.size() != 0)
      check_eq("cmd_addr", native_cmd_payload_addr, exp_cmd[0]);
    if (stall_prev)
      check_eq("cmd_hold", native_cmd_payload_addr, prev_addr);
    check_eq("r_valid", axi_r_valid, exp_rv);
    check_eq("rd_ready", native_rdata_ready,
             (exp_r.size() != 0) && !head_err && axi_r_ready);
    if (axi_r_valid && exp_r.size() != 0) begin
      check_eq("r_id", axi_r_payload_id, exp_r[0].id);
      check_eq("r_resp", axi_r_payload_resp, exp_r[0].err ? 2 : 0);
      check_eq("r_last", axi_r_last, exp_r[0].last);
      check_eq("r_data", axi_r_payload_data, exp_r[0].data);
    end

    ar_fire  = axi_ar_valid && axi_ar_ready;
    cmd_fire = native_cmd_valid && native_cmd_ready;
    rd_fire  = native_rdata_valid && native_rdata_ready;
    r_fire   = axi_r_valid && axi_r_ready;
    stall_prev = native_cmd_valid && !native_cmd_ready;
    prev_addr  = native_cmd_payload_addr;

    if (cmd_fire) begin
      mem_q.push_back(memfn(native_cmd_payload_addr));
      cmd_log.push_back(native_cmd_payload_addr);
      if (exp_cmd.size() != 0) void'(exp_cmd.pop_front());
    end
    if (rd_fire && mem_q.size() != 0) void'(mem_q.pop_front());
    if (r_fire) begin
      r_fires++;
      if (exp_r.size() != 0) begin
        if (exp_r[0].last) outst--;
        void'(exp_r.pop_front());
      end
    end
    if (ar_fire)
      model_ar(axi_ar_payload_addr, axi_ar_payload_burst, axi_ar_payload_len,
               axi_ar_payload_size, axi_ar_payload_id);

    @(posedge clk);
    #1;
    if (ar_fire) axi_ar_valid = 1'b0;
    native_cmd_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
    axi_r_ready      = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
    if (!(native_rdata_valid && !rd_fire))
      native_rdata_valid = !hold && (mem_q.size() != 0) &&
                           (!rnd || ($urandom_range(0, 2) != 0));
    native_rdata_payload_data = (mem_q.size() != 0) ? mem_q[0] : '0;
  endtask

  task automatic start_ar(input logic [31:0] addr, input logic [1:0] burst,
                          input logic [7:0] len, input logic [2:0] size,
                          input logic [ID_W-1:0] id);
    axi_ar_payload_addr  = addr;
    axi_ar_payload_burst = burst;
    axi_ar_payload_len   = len;
    axi_ar_payload_size  = size;
    axi_ar_payload_id    = id;
    axi_ar_valid         = 1'b1;
  endtask

  task automatic wait_ar(input int limit);
    int n = 0;
    while (axi_ar_valid && n < limit) begin
      cycle();
      n++;
    end
    check_eq("ar_accept", axi_ar_valid, 0);
    axi_ar_valid = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((exp_r.size() != 0 || exp_cmd.size() != 0) && n < limit) begin
      cycle();
      n++;
    end
    check_eq("drain", exp_r.size() + exp_cmd.size(), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  wlens [4];
    logic [31:0] a;
    logic [1:0]  bu;
    logic [7:0]  ln;
    logic [2:0]  sz;
    int          r;
    wlens[0] = 8'd1; wlens[1] = 8'd3; wlens[2] = 8'd7; wlens[3] = 8'd15;

    rst = 1'b0;
    axi_ar_valid = 1'b0;
    axi_ar_payload_addr = '0;
    axi_ar_payload_burst = '0;
    axi_ar_payload_len = '0;
    axi_ar_payload_size = '0;
    axi_ar_payload_id = '0;
    axi_r_ready = 1'b1;
    native_cmd_ready = 1'b1;
    native_rdata_valid = 1'b0;
    native_rdata_payload_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst");
    rst = 1'b1;

    // INCR 0x1000 len 3 id 5
    cmd_log.delete(); r_fires = 0;
    start_ar(32'h1000, 2'd1, 8'd3, 3'd5, 4'd5);
    wait_ar(20);
    drain(100);
    check_eq("incr_ncmd", cmd_log.size(), 4);
    for (int i = 0; i < 4 && i < cmd_log.size(); i++)
      check_eq("incr_addr", cmd_log[i], 27'h80 + 27'(i));
    check_eq("incr_beats", r_fires, 4);

    // WRAP 0x1060 len 3
    cmd_log.delete(); r_fires = 0;
    start_ar(32'h1060, 2'd2, 8'd3, 3'd5, 4'd6);
    wait_ar(20);
    drain(100);
`ifdef AXI_RD_WRAP_EN
    check_eq("wrap_ncmd", cmd_log.size(), 4);
    if (cmd_log.size() == 4) begin
      check_eq("wrap_a0", cmd_log[0], 27'h83);
      check_eq("wrap_a1", cmd_log[1], 27'h80);
      check_eq("wrap_a2", cmd_log[2], 27'h81);
      check_eq("wrap_a3", cmd_log[3], 27'h82);
    end
`else
    check_eq("wrap_off_ncmd", cmd_log.size(), 0);
`endif
    check_eq("wrap_beats", r_fires, 4);

    // FIXED 0x2000 len 2
    cmd_log.delete();
    start_ar(32'h2000, 2'd0, 8'd2, 3'd5, 4'd7);
    wait_ar(20);
    drain(100);
    check_eq("fixed_ncmd", cmd_log.size(), 3);
    for (int i = 0; i < cmd_log.size(); i++)
      check_eq("fixed_addr", cmd_log[i], 27'h100);

    // Bad size: SLVERR beats, no native command
    cmd_log.delete(); r_fires = 0;
    start_ar(32'h3000, 2'd1, 8'd1, 3'd2, 4'd3);
    wait_ar(20);
    drain(100);
    check_eq("err_ncmd", cmd_log.size(), 0);
    check_eq("err_beats", r_fires, 2);

    // Tracking FIFO full with native data withheld
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start_ar(32'h4000 + 32'(i) * 32, 2'd1, 8'd0, 3'd5, 4'(i + 8));
      wait_ar(20);
    end
    repeat (2) cycle();
    check_eq("full_ar_ready", axi_ar_ready, 0);
    start_ar(32'h4080, 2'd1, 8'd0, 3'd5, 4'd12);
    repeat (6) cycle();
    check_eq("full_blocked", axi_ar_valid, 1);
    hold = 1'b0;
    wait_ar(50);
    drain(200);

    // 16-beat INCR with random stalls
    rnd = 1'b1;
    cmd_log.delete(); r_fires = 0;
    start_ar(32'h4000, 2'd1, 8'd15, 3'd5, 4'd9);
    wait_ar(20);
    drain(1000);
    check_eq("stall_ncmd", cmd_log.size(), 16);
    for (int i = 0; i < cmd_log.size(); i++)
      check_eq("stall_addr", cmd_log[i], 27'h200 + 27'(i));
    check_eq("stall_beats", r_fires, 16);

    // Reset in the middle of a burst
    rnd = 1'b0;
    start_ar(32'h5000, 2'd1, 8'd15, 3'd5, 4'd2);
    wait_ar(20);
    repeat (4) cycle();
    #2;
    rst = 1'b0;
    #1;
    check_reset("midrst");
    exp_cmd.delete(); exp_r.delete(); mem_q.delete();
    outst = 0; stall_prev = 1'b0;
    axi_ar_valid = 1'b0; native_rdata_valid = 1'b0;
    native_rdata_payload_data = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Address rollover at the top of the space
    start_ar(32'hFFFF_FFC0, 2'd1, 8'd3, 3'd5, 4'd1);
    wait_ar(20);
    drain(100);

    // Random traffic
    rnd = 1'b1;
    for (int n = 0; n < 40; n++) begin
      r  = $urandom_range(0, 9);
      bu = (r < 1) ? 2'd3 : (r < 4) ? 2'd2 : (r < 6) ? 2'd0 : 2'd1;
      sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd5;
      ln = 8'($urandom_range(0, 15));
      if (bu == 2'd2 && $urandom_range(0, 3) != 0) ln = wlens[$urandom_range(0, 3)];
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[4:0] = 5'd0;
      start_ar(a, bu, ln, sz, 4'($urandom_range(0, 15)));
      wait_ar(200);
      if ($urandom_range(0, 4) == 0) drain(2000);
    end
    drain(3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_rd_native_bridge.md
# axi_rd_native_bridge

Parametrised AXI4 read-channel (AR/R) to LiteDRAM native-port bridge, generalising the fixed 256-bit, 1-bit-ID AXI read channels to arbitrary data, address and ID widths. Splits FIXED, INCR and WRAP bursts into per-beat native read commands. Tracks up to `MAX_OUTST` in-flight bursts so R beats carry the correct ID, `last` and response. Sits between the AXI crossbar and the LiteDRAM user port, ahead of the bank crossbar.

## Interface
- `DATA_W`, 256, data width in bits, power of two ≥ 32; `BPB = DATA_W/8`, `OFS = log2(BPB)`.
- `ADDR_W`, 32, AXI byte-address width.
- `ID_W`, 4, AXI ID width.
- `MAX_OUTST`, 4, tracking-FIFO depth in bursts, power of two ≥ 2.

Ports:
- `clk`  in  1  single clock; all logic rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `axi_ar_valid` / `axi_ar_ready`  in / out  1  AR handshake.
- `axi_ar_payload_addr`  in  `ADDR_W`  start byte address.
- `axi_ar_payload_burst`  in  2  0 = FIXED, 1 = INCR, 2 = WRAP, 3 = reserved.
- `axi_ar_payload_len`  in  8  beats − 1.
- `axi_ar_payload_size`  in  3  log2 bytes per beat.
- `axi_ar_payload_id`  in  `ID_W`  transaction ID.
- `axi_r_valid` / `axi_r_ready`  out / in  1  R handshake.
- `axi_r_last`  out  1  final beat of burst.
- `axi_r_payload_resp`  out  2  OKAY = 0, SLVERR = 2.
- `axi_r_payload_data`  out  `DATA_W`  read data.
- `axi_r_payload_id`  out  `ID_W`  ID of head burst.
- `native_cmd_valid` / `native_cmd_ready`  out / in  1  native command handshake.
- `native_cmd_payload_we`  out  1  tied 0.
- `native_cmd_payload_addr`  out  `ADDR_W-OFS`  word address (byte address >> `OFS`).
- `native_rdata_valid` / `native_rdata_ready`  in / out  1  native read-data handshake.
- `native_rdata_payload_data`  in  `DATA_W`  read data, returned in command order.

## Operation
- Issue FSM, states IDLE and ISSUE.
- IDLE: `axi_ar_ready = !trk_full`. On AR handshake:
  - latch addr, burst, len;
  - clear beat counter `bc`;
  - push {id, len, err} to the tracking FIFO;
  - go to ISSUE if `err = 0`, otherwise stay in IDLE.
- `err = 1` when any of:
  - `size != OFS`;
  - `burst == 3`;
  - WRAP with `len` not in {1, 3, 7, 15};
  - WRAP with a start address not aligned to `BPB`.
- ISSUE: `native_cmd_valid = 1`. On each cmd handshake:
  - advance address: FIXED unchanged; INCR `+BPB`; WRAP `+BPB` within the block `(len+1)*BPB`, low bits wrap to block base;
  - `bc++`;
  - after the handshake with `bc == len`, return to IDLE.
- Address arithmetic is modulo `2^ADDR_W`. 4 KB boundary crossing is not checked.
- Response side, head entry with `err = 0`:
  - `axi_r_valid = native_rdata_valid`;
  - `native_rdata_ready = axi_r_ready`;
  - data passes through combinationally; `resp = 0`.
- Head entry with `err = 1`:
  - drive `len+1` beats with `axi_r_valid = 1`, `resp = 2`, data 0;
  - `native_rdata_ready = 0`.
- Response counter `rc` counts R handshakes.
  - `axi_r_last = (rc == head.len)`.
  - Pop the head entry and clear `rc` on the last handshake.
- Tracking FIFO empty: `axi_r_valid = 0`, `native_rdata_ready = 0`.

## Timing
- Reset values: FSM IDLE; FIFO empty; `bc = rc = 0`; outputs `axi_ar_ready = 1`, `axi_r_valid = 0`, `axi_r_last = 0`, `axi_r_payload_resp = 0`, `axi_r_payload_data = 0`, `axi_r_payload_id = 0`, `native_cmd_valid = 0`, `native_cmd_payload_addr = 0`, `native_rdata_ready = 0`.
- `axi_ar_ready` depends only on registered state and is not a function of `axi_ar_valid`.
- First native cmd is valid the cycle after the AR handshake. With `native_cmd_ready` held high, the bridge issues 1 cmd per cycle and is ready for the next AR the cycle after the last cmd.
- R path adds zero latency: R beat in the same cycle as `native_rdata_valid`.
- FIFO full plus pop in the same cycle: no push that cycle, because `ready` was computed before the pop.
- FIFO push and pop in the same cycle are both legal.
- `native_cmd_payload_addr` is stable while `native_cmd_valid && !native_cmd_ready`.
- `rst` asserted mid-burst: everything returns to reset state immediately; in-flight native data is dropped (the upstream reset resets the controller too).

## Configuration
- `AXI_RD_WRAP_EN`
  - Defined: WRAP bursts are supported as above.
  - Undefined: `burst == 2` sets `err = 1` and returns `len+1` SLVERR beats with no native commands; the wrap-address logic is not compiled in.

## Test plan
- INCR, addr 0x1000, len 3, id 5, `DATA_W` 256 → native addrs 0x80, 0x81, 0x82, 0x83; 4 R beats with id 5, resp 0, `last` on the 4th only.
- WRAP, addr 0x1060, len 3, macro defined → native addrs 0x83, 0x80, 0x81, 0x82.
- FIXED, addr 0x2000, len 2 → three cmds, all addr 0x100.
- `size = 2` with `DATA_W` 256, len 1, id 3 → no native cmd; 2 beats resp 2, data 0, id 3, `last` on the 2nd. The same error response occurs for WRAP when the macro is undefined.
- `MAX_OUTST = 4`: issue 5 single-beat ARs with native data withheld → `axi_ar_ready` low after the 4th acceptance. Release one R → the 5th AR is accepted; IDs return in order.
- Random `native_cmd_ready` / `axi_r_ready` stalls on a 16-beat INCR → addr held while stalled; no lost or duplicated beats; exactly 16 R beats.
